// File: rtl/hs32_bram_arb_if.sv
// Request/controller bus for hs32_bram_arb: two requester ports plus the
// strobe/ack port toward hs32_bram_ctl. Names are from the arbiter's side.
interface hs32_bram_arb_if #(
  parameter int AW = 12
);
  // requester port 0 (CPU data path) and port 1 (Wishbone/host)
  logic          i_stb0;
  logic          i_stb1;
  logic [AW-1:0] i_addr0;
  logic [AW-1:0] i_addr1;
  logic [31:0]   i_dwrite0;
  logic [31:0]   i_dwrite1;
  logic          i_rw0;
  logic          i_rw1;
  logic          o_ack0;
  logic          o_ack1;
  logic          o_err0;
  logic          o_err1;
  logic [31:0]   o_dread0;
  logic [31:0]   o_dread1;

  // BRAM controller side
  logic [AW-1:0] o_addr;
  logic [31:0]   o_dwrite;
  logic          o_rw;
  logic          o_stb;
  logic          i_ack;
  logic [31:0]   i_dread;

  modport slave (
    input  i_stb0, i_stb1, i_addr0, i_addr1, i_dwrite0, i_dwrite1, i_rw0, i_rw1,
    output o_ack0, o_ack1, o_err0, o_err1, o_dread0, o_dread1,
    output o_addr, o_dwrite, o_rw, o_stb,
    input  i_ack, i_dread
  );

  modport master (
    output i_stb0, i_stb1, i_addr0, i_addr1, i_dwrite0, i_dwrite1, i_rw0, i_rw1,
    input  o_ack0, o_ack1, o_err0, o_err1, o_dread0, o_dread1,
    input  o_addr, o_dwrite, o_rw, o_stb,
    output i_ack, i_dread
  );
endinterface

// File: rtl/hs32_bram_arb.sv
// Two-port arbiter/sequencer in front of hs32_bram_ctl with a WAIT watchdog.
// Define HS32_BRAM_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module hs32_bram_arb #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_reset,
  hs32_bram_arb_if.slave bus
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef HS32_BRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        r_state;
  logic [1:0]    r_pend;
  logic          r_last;
  logic          r_gnt;
  logic [WDW-1:0] r_wd;

  logic [AW-1:0] r_addr_h0;
  logic [AW-1:0] r_addr_h1;
  logic [31:0]   r_dw_h0;
  logic [31:0]   r_dw_h1;
  logic          r_rw_h0;
  logic          r_rw_h1;

  logic          r_stb;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_dw;
  logic [1:0]    r_ack;
  logic [1:0]    r_err;
  logic [31:0]   r_dread0;
  logic [31:0]   r_dread1;

  logic [1:0]    w_cap;
  logic [1:0]    w_clr;
  logic          w_gnt;
  logic          w_tmo;
  logic          w_done;

  assign w_cap = {bus.i_stb1 & ~r_pend[1], bus.i_stb0 & ~r_pend[0]};

  // last_grant is tracked in both builds; only round-robin consults it
  always_comb begin
    w_gnt = ~r_pend[0];
    if (RR_EN && (r_pend == 2'b11)) begin
      w_gnt = ~r_last;
    end
  end

  assign w_tmo  = (TIMEOUT != 0) && ((int'(r_wd) + 1) == TIMEOUT);
  assign w_done = (r_state == S_WAIT) && (bus.i_ack || w_tmo);
  assign w_clr  = w_done ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_addr_h0 <= '0;
      r_addr_h1 <= '0;
      r_dw_h0   <= '0;
      r_dw_h1   <= '0;
      r_rw_h0   <= 1'b1;
      r_rw_h1   <= 1'b1;
    end else begin
      if (w_cap[0]) begin
        r_addr_h0 <= bus.i_addr0;
        r_dw_h0   <= bus.i_dwrite0;
        r_rw_h0   <= bus.i_rw0;
      end
      if (w_cap[1]) begin
        r_addr_h1 <= bus.i_addr1;
        r_dw_h1   <= bus.i_dwrite1;
        r_rw_h1   <= bus.i_rw1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_pend   <= '0;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_wd     <= '0;
      r_stb    <= 1'b0;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_dw     <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_dread0 <= '0;
      r_dread1 <= '0;
    end else begin
      // a new capture never collides with the clear: the granted port is pending
      r_pend <= (r_pend | w_cap) & ~w_clr;
      r_ack  <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_gnt   <= w_gnt;
            r_last  <= w_gnt;
            r_addr  <= w_gnt ? r_addr_h1 : r_addr_h0;
            r_dw    <= w_gnt ? r_dw_h1   : r_dw_h0;
            r_rw    <= w_gnt ? r_rw_h1   : r_rw_h0;
            r_stb   <= 1'b1;
            r_wd    <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_stb   <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_ack) begin
            if (r_rw) begin
              if (r_gnt) r_dread1 <= bus.i_dread;
              else       r_dread0 <= bus.i_dread;
            end
            r_ack[r_gnt] <= 1'b1;
            r_state      <= S_IDLE;
          end else if (w_tmo) begin
            r_ack[r_gnt] <= 1'b1;
            r_err[r_gnt] <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_stb    = r_stb;
  assign bus.o_addr   = r_addr;
  assign bus.o_dwrite = r_dw;
  assign bus.o_rw     = r_rw;
  assign bus.o_ack0   = r_ack[0];
  assign bus.o_ack1   = r_ack[1];
  assign bus.o_err0   = r_err[0];
  assign bus.o_err1   = r_err[1];
  assign bus.o_dread0 = r_dread0;
  assign bus.o_dread1 = r_dread1;
endmodule

// File: tb/tb_hs32_bram_arb.sv
// Scoreboard bench for hs32_bram_arb: directed scenarios plus random traffic
// checked against a request-level model of pending flags, arbitration and data.
module tb_hs32_bram_arb;
  localparam int AW  = 12;
  localparam int TMO = 15;
`ifdef HS32_BRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0] dread;
    logic        err;
    int          cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hs32_bram_arb_if #(.AW(AW)) bus ();
  hs32_bram_arb #(.AW(AW), .TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [31:0]   ref_mem [int];
  logic [31:0]   ref_last [2];
  logic [31:0]   ctl_mem [int];
  bit            ctl_noack;
  exp_t          expq0 [$];
  exp_t          expq1 [$];
  logic [AW-1:0] rq_addr [2];
  logic [31:0]   rq_dw [2];
  logic          rq_rw [2];
  int            rq_cyc [2];
  int            rq_lat [2];
  logic [31:0]   dread_m [2];
  logic [1:0]    pend_m;
  logic [1:0]    prev_stb;
  logic          prev_rst;
  int            last_m;
  bit            busy;
  int            busy_p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int p, input logic stb, input logic [AW-1:0] a,
                       input logic [31:0] dw, input logic rw);
    if (p == 0) begin
      bus.i_stb0 = stb; bus.i_addr0 = a; bus.i_dwrite0 = dw; bus.i_rw0 = rw;
    end else begin
      bus.i_stb1 = stb; bus.i_addr1 = a; bus.i_dwrite1 = dw; bus.i_rw1 = rw;
    end
  endtask

  task automatic issue(input int p, input logic rw, input logic [AW-1:0] a,
                       input logic [31:0] dw, input int lat, input bit tmo);
    exp_t e;
    e.err = tmo;
    if (tmo || !rw) e.dread = ref_last[p];
    else            e.dread = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    if (!rw && !tmo) ref_mem[int'(a)] = dw;
    ref_last[p] = e.dread;
    e.cyc = cyc;
    e.lat = lat;
    if (p == 0) expq0.push_back(e);
    else        expq1.push_back(e);
    rq_addr[p] = a; rq_dw[p] = dw; rq_rw[p] = rw; rq_cyc[p] = cyc; rq_lat[p] = lat;
    drive(p, 1'b1, a, dw, rw);
    @(posedge clk);
    #1;
    drive(p, 1'b0, AW'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic wait_ack(input int p, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((p == 0) ? bus.o_ack0 : bus.o_ack1) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("ack%0d_arrival", p), 64'(got), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    expq0.delete();
    expq1.delete();
    busy = 1'b0;
    dread_m[0] = '0; dread_m[1] = '0;
    ref_last[0] = '0; ref_last[1] = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_stb",    64'(bus.o_stb), 64'(0));
    chk("rst_ack",    64'({bus.o_ack1, bus.o_ack0}), 64'(0));
    chk("rst_err",    64'({bus.o_err1, bus.o_err0}), 64'(0));
    chk("rst_dread0", 64'(bus.o_dread0), 64'(0));
    chk("rst_dread1", 64'(bus.o_dread1), 64'(0));
    chk("rst_addr",   64'(bus.o_addr), 64'(0));
    chk("rst_dwrite", 64'(bus.o_dwrite), 64'(0));
    chk("rst_rw",     64'(bus.o_rw), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // BRAM controller: acks the cycle after each strobe unless told to stall
  initial begin : ctl
    logic [AW-1:0] a;
    logic          rw;
    logic [31:0]   dw;
    bus.i_ack = 1'b0;
    bus.i_dread = $urandom;
    forever begin
      @(negedge clk);
      if (bus.o_stb === 1'b1 && !ctl_noack) begin
        a = bus.o_addr; rw = bus.o_rw; dw = bus.o_dwrite;
        @(posedge clk);
        #1;
        bus.i_ack = 1'b1;
        if (rw) bus.i_dread = ctl_mem.exists(int'(a)) ? ctl_mem[int'(a)] : 32'h0;
        else begin
          bus.i_dread = $urandom;
          ctl_mem[int'(a)] = dw;
        end
        @(posedge clk);
        #1;
        bus.i_ack = 1'b0;
        bus.i_dread = $urandom;
      end
    end
  end

  // monitor: tracks pending requests per cycle and checks every output
  initial begin : monitor
    logic [1:0]  ack, err, cur, decide;
    logic [31:0] dr [2];
    bit          bp, have;
    int          e;
    exp_t        x;
    pend_m = '0; prev_stb = '0; prev_rst = 1'b0; last_m = 1; busy = 1'b0; busy_p = 0;
    forever begin
      @(negedge clk);
      ack = {bus.o_ack1, bus.o_ack0};
      err = {bus.o_err1, bus.o_err0};
      dr[0] = bus.o_dread0;
      dr[1] = bus.o_dread1;
      decide = prev_rst ? pend_m : 2'b00;
      for (int p = 0; p < 2; p++)
        cur[p] = prev_rst && !ack[p] && (pend_m[p] || prev_stb[p]);
      if (!prev_rst) last_m = 1;
      if (rst_n) begin
        bp = busy;
        chk("ack_exclusive", 64'(ack == 2'b11), 64'(0));
        for (int p = 0; p < 2; p++) begin
          if (ack[p]) begin
            have = (p == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
            n_checks++;
            if (!have) begin
              n_err++;
              $display("FAIL unexpected_ack%0d: got ack expected none (cycle %0d)", p, cyc);
            end else begin
              x = (p == 0) ? expq0.pop_front() : expq1.pop_front();
              chk($sformatf("dread%0d", p), 64'(dr[p]), 64'(x.dread));
              chk($sformatf("err%0d", p), 64'(err[p]), 64'(x.err));
              if (x.lat >= 0) chk($sformatf("ack%0d_latency", p), 64'(cyc - x.cyc), 64'(x.lat));
              chk($sformatf("ack%0d_port", p), 64'(busy && busy_p == p), 64'(1));
              dread_m[p] = x.dread;
              busy = 1'b0;
            end
          end else begin
            chk($sformatf("err%0d_without_ack", p), 64'(err[p]), 64'(0));
          end
          chk($sformatf("dread%0d_hold", p), 64'(dr[p]), 64'(dread_m[p]));
        end
        if (bp) begin
          chk("stb_while_busy", 64'(bus.o_stb), 64'(0));
          chk("hold_addr",   64'(bus.o_addr),   64'(rq_addr[busy_p]));
          chk("hold_dwrite", 64'(bus.o_dwrite), 64'(rq_dw[busy_p]));
          chk("hold_rw",     64'(bus.o_rw),     64'(rq_rw[busy_p]));
        end else begin
          chk("stb_issue", 64'(bus.o_stb), 64'(decide != 2'b00));
          if (bus.o_stb && decide != 2'b00) begin
            if (decide == 2'b11) e = RR ? ((last_m == 1) ? 0 : 1) : 0;
            else                 e = decide[0] ? 0 : 1;
            chk($sformatf("grant%0d_addr", e),   64'(bus.o_addr),   64'(rq_addr[e]));
            chk($sformatf("grant%0d_dwrite", e), 64'(bus.o_dwrite), 64'(rq_dw[e]));
            chk($sformatf("grant%0d_rw", e),     64'(bus.o_rw),     64'(rq_rw[e]));
            if (rq_lat[e] == 4) chk("stb_latency", 64'(cyc - rq_cyc[e]), 64'(2));
            last_m = e;
            busy = 1'b1;
            busy_p = e;
          end
        end
      end
      prev_stb = {bus.i_stb1, bus.i_stb0};
      prev_rst = rst_n;
      pend_m = cur;
    end
  end

  task automatic rand_port(input int p, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a = (p == 0) ? AW'($urandom_range(0, 31)) : AW'(2048 + $urandom_range(0, 31));
      issue(p, 1'($urandom), a, $urandom, -1, 1'b0);
      wait_ack(p, 60);
    end
  endtask

  initial begin : main
    drive(0, 1'b0, '0, '0, 1'b1);
    drive(1, 1'b0, '0, '0, 1'b1);
    ctl_noack = 1'b0;
    do_reset(2);

    // single read with 4-cycle latency
    ctl_mem[16'h010] = 32'hDEADBEEF;
    ref_mem[16'h010] = 32'hDEADBEEF;
    issue(0, 1'b1, AW'(12'h010), $urandom, 4, 1'b0);
    wait_ack(0, 20);

    // write then unaligned read on port 1
    issue(1, 1'b0, AW'(12'h021), 32'h11223344, 4, 1'b0);
    wait_ack(1, 20);
    issue(1, 1'b1, AW'(12'h021), $urandom, 4, 1'b0);
    wait_ack(1, 20);

    // simultaneous strobes from a fresh last_grant
    do_reset(1);
    repeat (3) begin
      fork
        issue(0, 1'b1, AW'($urandom_range(0, 63)), $urandom, 4, 1'b0);
        issue(1, 1'b0, AW'(2048 + $urandom_range(0, 63)), $urandom, 7, 1'b0);
      join
      fork
        wait_ack(0, 40);
        wait_ack(1, 40);
      join
    end

    // port 0 re-strobes right after each ack while port 1 waits
    fork
      begin
        issue(1, 1'b1, AW'(2048 + $urandom_range(0, 63)), $urandom, 7, 1'b0);
        wait_ack(1, 40);
      end
      begin
        issue(0, 1'b1, AW'($urandom_range(0, 63)), $urandom, 4, 1'b0);
        wait_ack(0, 40);
        repeat (3) begin
          issue(0, 1'($urandom), AW'($urandom_range(0, 63)), $urandom, -1, 1'b0);
          wait_ack(0, 40);
        end
      end
    join

    // watchdog abort, then normal traffic resumes
    ctl_noack = 1'b1;
    issue(0, 1'b1, AW'(12'h010), $urandom, 3 + TMO, 1'b1);
    wait_ack(0, 60);
    ctl_noack = 1'b0;
    issue(0, 1'b1, AW'(12'h010), $urandom, 4, 1'b0);
    wait_ack(0, 20);

    // reset during WAIT: the request vanishes without ack or err
    issue(0, 1'b1, AW'(12'h010), $urandom, -1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_reset(1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    issue(1, 1'b1, AW'(12'h021), $urandom, 4, 1'b0);
    wait_ack(1, 20);

    // random concurrent traffic on disjoint address ranges
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : guard
    #2000000;
    $display("FAIL sim_time_limit: got no end expected $finish (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1);
  end
endmodule

// File: doc/hs32_bram_arb.md
Name: hs32_bram_arb

Overview:
- Two-requester arbiter and sequencer in front of hs32_bram_ctl's strobe/ack port.
- Port 0 is the HS32 CPU data path; port 1 is the Wishbone/host side (firmware load, debug).
- Latches each request, grants one at a time, and drives a single-cycle o_stb to the BRAM controller.
- Holds address and write data stable until the controller's ack, then returns read data and a per-port ack.

Parameters:
AW, 12, byte address width (matches hs32_bram_ctl addr_width)
TIMEOUT, 15, max cycles in WAIT before abort; 0 disables the watchdog; counter width $clog2(TIMEOUT+1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_stb0 / i_stb1  in  1  request strobe, per port
i_addr0 / i_addr1  in  AW  byte address
i_dwrite0 / i_dwrite1  in  32  write data
i_rw0 / i_rw1  in  1  1 = read, 0 = write
o_ack0 / o_ack1  out  1  one-cycle completion pulse
o_err0 / o_err1  out  1  one-cycle pulse with ack on timeout abort
o_dread0 / o_dread1  out  32  read data, registered
o_addr  out  AW  to controller i_addr
o_dwrite  out  32  to controller i_dwrite
o_rw  out  1  to controller i_rw
o_stb  out  1  to controller i_stb
i_ack  in  1  from controller o_ack
i_dread  in  32  from controller o_dread; valid in the i_ack cycle

Behaviour:
- Reset values (i_reset=0 at posedge):
  - all pending flags, o_stb, o_ack*, o_err* = 0; o_dread* = 0.
  - o_addr = 0, o_dwrite = 0, o_rw = 1.
  - state = IDLE, last_grant = 1, watchdog = 0.
- Request capture:
  - i_stbN=1 with pendN=0: latch addr/dwrite/rw into holding regN and set pendN at the clock edge.
  - i_stbN while pendN=1 is ignored; no side effects.
  - Requesters must not re-strobe before their ack.
  - A capture may coincide with any state, including the other port's grant or completion.
- FSM (registered outputs):
  - IDLE: if any pend, pick grant g. Load o_addr/o_dwrite/o_rw from regg, set o_stb=1, go to ISSUE.
  - ISSUE (one cycle, o_stb=1): clear o_stb at the edge; go to WAIT. o_addr/o_dwrite/o_rw stay held.
  - WAIT, i_ack=1:
    - Read: capture i_dread into o_dreadg. Write: o_dreadg unchanged.
    - Clear pendg, pulse o_ackg next cycle, go to IDLE.
  - WAIT, i_ack=0: watchdog increments. At watchdog==TIMEOUT (TIMEOUT>0): clear pendg, pulse o_ackg and o_errg together, o_dreadg unchanged, go to IDLE.
  - Watchdog clears on entry to ISSUE.
- Timing:
  - i_stbN at cycle N → o_stb at N+2 → i_ack at N+3 → o_ackN and o_dreadN at N+4.
  - Back-to-back: next o_stb no earlier than the cycle after o_ack. o_stb never asserts while the controller is busy.
- Arbitration (default): fixed priority, port 0 wins ties. last_grant updates on every grant.
- o_ack0 and o_ack1 are never high in the same cycle.
- i_ack outside WAIT is ignored.
- Reset mid-transaction (any state): abort immediately. No ack or err is issued, and both pending flags are dropped.

Optional Feature:
- HS32_BRAM_ARB_RR_EN defined: round-robin. When both ports are pending in IDLE, grant the port != last_grant. A single pending port is always granted.
- Not defined: fixed priority, port 0 first. last_grant is still maintained but unused for the decision.

Test Plan:
- Single read:
  - Preload the model so the controller returns 0xDEADBEEF.
  - i_stb0, i_addr0=0x010, i_rw0=1 at cycle 0.
  - Expect: o_stb at cycle 2 with o_addr=0x010; o_ack0 at cycle 4 with o_dread0=0xDEADBEEF; o_err0=0.
- Write then unaligned read on port 1:
  - Write 0x11223344 to 0x021 (i_rw1=0). Expect o_ack1; o_dread1 unchanged; o_rw=0 held from ISSUE through WAIT.
  - Read 0x021. Expect o_dread1=0x11223344.
- Simultaneous strobes:
  - i_stb0 and i_stb1 in the same cycle, repeated 3 times.
  - Default: grants 0,1,0,1,0,1, port 0 always served first in each pair.
  - With HS32_BRAM_ARB_RR_EN: first grant is 0 (last_grant=1 after reset), then grants alternate.
- Starvation check (default build):
  - Port 0 re-strobes the cycle after each o_ack0 while port 1 stays pending.
  - Expect port 1 served only when pend0=0 in IDLE.
  - Under RR: port 1 is served within 2 transactions.
- Timeout:
  - Controller model never acks; TIMEOUT=15.
  - Expect o_ack0=o_err0=1 for one cycle, 15 cycles after entering WAIT.
  - Next request proceeds normally.
- Reset mid-op:
  - Drive i_reset=0 in the WAIT cycle. Expect no ack or err.
  - After release: o_stb=0, state IDLE; a new i_stb1 completes with 4-cycle latency.
